motion_mask_split: RTL and testbench

- Producer stage that feeds the highlight stage's two input FIFOs.
- Pops one RGB frame pixel and one 8-bit background luma sample, computes frame luma and its absolute difference from background, and thresholds it into a motion mask.
- Pushes the mask word to the mask FIFO and the unmodified frame pixel to the frame FIFO.
- The two outputs stay pixel-aligned, so the downstream stage can pair them by read order.

---
 rtl/motion_mask_split_if.sv | 27 ++
 rtl/motion_mask_split.sv | 120 ++++++++++++
 tb/tb_motion_mask_split.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/motion_mask_split_if.sv
// FIFO-side signal bundle for motion_mask_split: two FWFT input FIFOs and two output FIFOs.
// The block uses the master view; the surrounding FIFOs or a testbench use the slave view.
interface motion_mask_split_if;
    logic        in_rd_en;
    logic        in_empty;
    logic [23:0] in_dout;
    logic        bg_rd_en;
    logic        bg_empty;
    logic [7:0]  bg_dout;
    logic        mask_wr_en;
    logic        mask_full;
    logic [23:0] mask_din;
    logic        fr_wr_en;
    logic        fr_full;
    logic [23:0] fr_din;
    logic        frame_done;

    modport master (
        output in_rd_en, bg_rd_en, mask_wr_en, mask_din, fr_wr_en, fr_din, frame_done,
        input  in_empty, in_dout, bg_empty, bg_dout, mask_full, fr_full
    );

    modport slave (
        input  in_rd_en, bg_rd_en, mask_wr_en, mask_din, fr_wr_en, fr_din, frame_done,
        output in_empty, in_dout, bg_empty, bg_dout, mask_full, fr_full
    );
endinterface

// File: rtl/motion_mask_split.sv
// Pops a frame pixel plus background luma, thresholds the luma difference into a motion mask,
// and pushes mask and pixel to two pixel-aligned output FIFOs.
module motion_mask_split #(
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 540,
    parameter int unsigned THRESHOLD  = 50,
    parameter logic [23:0] MASK_ON    = 24'hFFFFFF
) (
    input logic               clock,
    input logic               reset,
    motion_mask_split_if.master bus
);

    localparam int unsigned PIX_PER_FRAME = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned CNT_W         = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_FRAME - 1);
    localparam logic [7:0]  THRESH8       = 8'(THRESHOLD);

    typedef enum logic [1:0] {
        S_READ,
        S_CALC,
        S_WRITE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [23:0]      pix_q;
    logic [7:0]       bg_q;
    logic [23:0]      mask_q;
    logic             mask_done_q;
    logic             fr_done_q;
    logic             frame_done_q;

    logic [15:0]      luma_sum_c;
    logic [7:0]       y_c;
    logic [7:0]       diff_c;
    logic [23:0]      mask_d;
    logic             pop_c;
    logic             mask_wr_c;
    logic             fr_wr_c;
    logic             both_done_c;

    // BT.601-style integer luma of the held pixel and its distance from background
    always_comb begin
        luma_sum_c = 16'd77  * {8'd0, pix_q[23:16]}
                   + 16'd150 * {8'd0, pix_q[15:8]}
                   + 16'd29  * {8'd0, pix_q[7:0]};
        y_c        = 8'(luma_sum_c >> 8);
        diff_c     = (y_c >= bg_q) ? (y_c - bg_q) : (bg_q - y_c);
        mask_d     = (diff_c > THRESH8) ? MASK_ON : 24'h000000;
    end

    // Strobes follow state and FIFO flags; both inputs are popped together or not at all
    always_comb begin
        pop_c       = 1'b0;
        mask_wr_c   = 1'b0;
        fr_wr_c     = 1'b0;
        both_done_c = 1'b0;
        if (!reset) begin
            pop_c       = (state_q == S_READ) && !bus.in_empty && !bus.bg_empty;
            mask_wr_c   = (state_q == S_WRITE) && !mask_done_q && !bus.mask_full;
            fr_wr_c     = (state_q == S_WRITE) && !fr_done_q && !bus.fr_full;
            both_done_c = (state_q == S_WRITE) && (mask_done_q || mask_wr_c)
                                               && (fr_done_q || fr_wr_c);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_READ;
            cnt_q        <= '0;
            pix_q        <= '0;
            bg_q         <= '0;
            mask_q       <= '0;
            mask_done_q  <= 1'b0;
            fr_done_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_READ: begin
                    if (pop_c) begin
                        pix_q   <= bus.in_dout;
                        bg_q    <= bus.bg_dout;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    mask_q      <= mask_d;
                    mask_done_q <= 1'b0;
                    fr_done_q   <= 1'b0;
                    state_q     <= S_WRITE;
                end
                S_WRITE: begin
                    if (mask_wr_c) mask_done_q <= 1'b1;
                    if (fr_wr_c)   fr_done_q   <= 1'b1;
                    if (both_done_c) begin
                        state_q <= S_READ;
                        if (cnt_q == LAST_PIX) begin
                            cnt_q        <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= S_READ;
            endcase
        end
    end

    assign bus.in_rd_en   = pop_c;
    assign bus.bg_rd_en   = pop_c;
    assign bus.mask_wr_en = mask_wr_c;
    assign bus.fr_wr_en   = fr_wr_c;
    assign bus.mask_din   = mask_q;
    assign bus.fr_din     = pix_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_motion_mask_split.sv
// Directed bench for motion_mask_split on a 4x2 frame: threshold vectors, backpressure,
// input starvation, frame wrap and mid-write reset.
module tb_motion_mask_split;

    localparam int unsigned W = 4;
    localparam int unsigned H = 2;
    localparam int unsigned FRAME_PIX = W * H;

    typedef struct {
        logic [23:0] pix;
        logic [7:0]  bg;
        logic [23:0] mask;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   pix_cnt;
    logic fd_pending;
    vec_t vecs[7];

    motion_mask_split_if mm_if ();

    motion_mask_split #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .THRESHOLD (50),
        .MASK_ON   (24'hFFFFFF)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (mm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_pixel();
        fd_pending = (pix_cnt == FRAME_PIX - 1);
        pix_cnt    = (pix_cnt + 1) % FRAME_PIX;
    endtask

    // One cycle with both inputs empty; checks the frame_done pulse model
    task automatic idle_cycle(input string name);
        mm_if.in_empty = 1'b1;
        mm_if.bg_empty = 1'b1;
        #2;
        check({name, "_frame_done"}, 32'(mm_if.frame_done), 32'(fd_pending));
        check({name, "_no_pop"}, 32'(mm_if.in_rd_en | mm_if.bg_rd_en), 32'd0);
        fd_pending = 1'b0;
        tick();
    endtask

    // Full pixel with no backpressure: pop at N, writes at N+2
    task automatic do_pixel(input string name, input logic [23:0] pix, input logic [7:0] bg,
                            input logic [23:0] exp_mask);
        mm_if.in_empty  = 1'b0;
        mm_if.bg_empty  = 1'b0;
        mm_if.in_dout   = pix;
        mm_if.bg_dout   = bg;
        mm_if.mask_full = 1'b0;
        mm_if.fr_full   = 1'b0;
        #2;
        check({name, "_pop"}, 32'({mm_if.in_rd_en, mm_if.bg_rd_en}), 32'b11);
        check({name, "_frame_done"}, 32'(mm_if.frame_done), 32'(fd_pending));
        fd_pending = 1'b0;
        tick();
        mm_if.in_empty = 1'b1;
        mm_if.bg_empty = 1'b1;
        mm_if.in_dout  = 24'h0;
        mm_if.bg_dout  = 8'h0;
        #2;
        check({name, "_calc_quiet"}, 32'({mm_if.in_rd_en, mm_if.mask_wr_en, mm_if.fr_wr_en}), 32'd0);
        tick();
        #2;
        check({name, "_wr"}, 32'({mm_if.mask_wr_en, mm_if.fr_wr_en}), 32'b11);
        check({name, "_mask"}, 32'(mm_if.mask_din), 32'(exp_mask));
        check({name, "_pix"}, 32'(mm_if.fr_din), 32'(pix));
        tick();
        finish_pixel();
    endtask

    initial begin
        int fr_pulses;
        int mask_pulses;
        int pops;
        int wr_pulses;

        n_checks   = 0;
        n_fail     = 0;
        pix_cnt    = 0;
        fd_pending = 1'b0;

        vecs[0] = '{pix: 24'h808080, bg: 8'h80, mask: 24'h000000};  // equal luma
        vecs[1] = '{pix: 24'h808080, bg: 8'd78, mask: 24'h000000};  // diff 50, not strict
        vecs[2] = '{pix: 24'h808080, bg: 8'd77, mask: 24'hFFFFFF};  // diff 51
        vecs[3] = '{pix: 24'hFF0000, bg: 8'd0,  mask: 24'hFFFFFF};  // y=76
        vecs[4] = '{pix: 24'h000000, bg: 8'd0,  mask: 24'h000000};
        vecs[5] = '{pix: 24'h0000FF, bg: 8'd200, mask: 24'hFFFFFF}; // y=28, diff 172
        vecs[6] = '{pix: 24'h00FF00, bg: 8'd149, mask: 24'h000000}; // y=149, diff 0

        rst             = 1'b1;
        mm_if.in_empty  = 1'b1;
        mm_if.bg_empty  = 1'b1;
        mm_if.in_dout   = 24'h0;
        mm_if.bg_dout   = 8'h0;
        mm_if.mask_full = 1'b0;
        mm_if.fr_full   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #2;
        check("rst_strobes", 32'({mm_if.in_rd_en, mm_if.bg_rd_en, mm_if.mask_wr_en, mm_if.fr_wr_en}), 32'd0);
        check("rst_mask_din", 32'(mm_if.mask_din), 32'd0);
        check("rst_fr_din", 32'(mm_if.fr_din), 32'd0);
        check("rst_frame_done", 32'(mm_if.frame_done), 32'd0);
        tick();

        for (int i = 0; i < 7; i++)
            do_pixel($sformatf("vec%0d", i), vecs[i].pix, vecs[i].bg, vecs[i].mask);

        // Backpressure on the mask FIFO; pixel 0x102030 has y=29, bg 200 -> motion
        mm_if.in_empty = 1'b0;
        mm_if.bg_empty = 1'b0;
        mm_if.in_dout  = 24'h102030;
        mm_if.bg_dout  = 8'd200;
        #2;
        check("bp_pop", 32'({mm_if.in_rd_en, mm_if.bg_rd_en}), 32'b11);
        tick();
        mm_if.in_dout   = 24'hABCDEF;
        mm_if.bg_dout   = 8'd1;
        mm_if.mask_full = 1'b1;
        tick();
        fr_pulses   = 0;
        mask_pulses = 0;
        pops        = 0;
        for (int c = 0; c < 5; c++) begin
            #2;
            if (c == 0) check("bp_fr_first", 32'(mm_if.fr_wr_en), 32'd1);
            fr_pulses   += int'(mm_if.fr_wr_en);
            mask_pulses += int'(mm_if.mask_wr_en);
            pops        += int'(mm_if.in_rd_en | mm_if.bg_rd_en);
            tick();
        end
        check("bp_fr_count", 32'(fr_pulses), 32'd1);
        check("bp_mask_stalled", 32'(mask_pulses), 32'd0);
        check("bp_no_pop", 32'(pops), 32'd0);
        mm_if.mask_full = 1'b0;
        mm_if.in_empty  = 1'b1;
        mm_if.bg_empty  = 1'b1;
        #2;
        check("bp_mask_wr", 32'({mm_if.mask_wr_en, mm_if.fr_wr_en}), 32'b10);
        check("bp_mask_din", 32'(mm_if.mask_din), 32'hFFFFFF);
        check("bp_fr_din", 32'(mm_if.fr_din), 32'h102030);
        tick();
        finish_pixel();

        // Starvation: frame pixel available, background missing
        mm_if.in_empty = 1'b0;
        mm_if.in_dout  = 24'h808080;
        for (int c = 0; c < 4; c++) begin
            mm_if.bg_empty = 1'b1;
            #2;
            check($sformatf("starve%0d_no_pop", c), 32'({mm_if.in_rd_en, mm_if.bg_rd_en}), 32'd0);
            check($sformatf("starve%0d_frame_done", c), 32'(mm_if.frame_done), 32'(fd_pending));
            fd_pending = 1'b0;
            tick();
        end
        do_pixel("after_wrap", 24'h808080, 8'd77, 24'hFFFFFF);

        // Reset while both writes are blocked: the held pixel must vanish
        mm_if.in_empty = 1'b0;
        mm_if.bg_empty = 1'b0;
        mm_if.in_dout  = 24'h123456;
        mm_if.bg_dout  = 8'd0;
        #2;
        check("rstw_pop", 32'({mm_if.in_rd_en, mm_if.bg_rd_en}), 32'b11);
        tick();
        mm_if.in_empty  = 1'b1;
        mm_if.bg_empty  = 1'b1;
        mm_if.mask_full = 1'b1;
        mm_if.fr_full   = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst             = 1'b0;
        mm_if.mask_full = 1'b0;
        mm_if.fr_full   = 1'b0;
        #2;
        check("rstw_strobes", 32'({mm_if.in_rd_en, mm_if.bg_rd_en, mm_if.mask_wr_en, mm_if.fr_wr_en}), 32'd0);
        check("rstw_mask_din", 32'(mm_if.mask_din), 32'd0);
        check("rstw_fr_din", 32'(mm_if.fr_din), 32'd0);
        check("rstw_frame_done", 32'(mm_if.frame_done), 32'd0);
        wr_pulses = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            #2;
            wr_pulses += int'(mm_if.mask_wr_en | mm_if.fr_wr_en);
        end
        check("rstw_no_late_write", 32'(wr_pulses), 32'd0);
        tick();
        pix_cnt    = 0;
        fd_pending = 1'b0;

        // Counter restarted at 0: frame_done only after 8 more pixels
        for (int i = 0; i < int'(FRAME_PIX); i++)
            do_pixel($sformatf("post_rst%0d", i), vecs[i % 7].pix, vecs[i % 7].bg, vecs[i % 7].mask);
        idle_cycle("post_rst_pulse");
        idle_cycle("post_rst_pulse_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
